hw_accel_window_3x3: RTL and testbench



---
 rtl/hw_accel_window_3x3_if.sv | 27 ++
 rtl/hw_accel_window_3x3.sv | 221 ++++++++++++++++++++++
 tb/tb_hw_accel_window_3x3.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hw_accel_window_3x3_if.sv
// Pixel-stream input and 3x3 window output bundle of the window generator.
// The slave modport is the generator itself; master is the surrounding logic.
interface hw_accel_window_3x3_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  logic [DATA_WIDTH-1:0]         pixel_in;
  logic                          pixel_in_valid;
  logic                          pixel_in_ready;
  logic [9*DATA_WIDTH-1:0]       win_out;
  logic                          win_valid;
  logic [$clog2(IMG_HEIGHT)-1:0] win_row;
  logic [$clog2(IMG_WIDTH)-1:0]  win_col;
  logic                          win_last;
  logic                          err_drop;

  modport master (
    output pixel_in, pixel_in_valid,
    input  pixel_in_ready, win_out, win_valid, win_row, win_col, win_last, err_drop
  );

  modport slave (
    input  pixel_in, pixel_in_valid,
    output pixel_in_ready, win_out, win_valid, win_row, win_col, win_last, err_drop
  );
endinterface

// File: rtl/hw_accel_window_3x3.sv
// Streaming zero-padded 3x3 window generator: two line buffers plus a two-column
// history; after the last pixel it replays a virtual all-zero row to flush the frame.
module hw_accel_window_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic                  clk,
  input logic                  rst_n,
  hw_accel_window_3x3_if.slave bus
);

  localparam int DW  = DATA_WIDTH;
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int FW  = $clog2(IMG_WIDTH + 1);
  localparam int CLW = 3 * DW;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    in_col_q, in_col_d;
  logic [RW-1:0]    in_row_q, in_row_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]    out_col_q, out_col_d;
  logic [RW-1:0]    out_row_q, out_row_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic [RW-1:0]    win_row_q, win_row_d;
  logic [CW-1:0]    win_col_q, win_col_d;
  logic [9*DW-1:0]  win_q, win_d;

  // Column vectors pack {row y+1, row y, row y-1} from MSB to LSB.
  logic [CLW-1:0]   col_a_q, col_a_d;
  logic [CLW-1:0]   col_b_q, col_b_d;

  logic [DW-1:0]    lb_top_mem [IMG_WIDTH];
  logic [DW-1:0]    lb_mid_mem [IMG_WIDTH];

  logic             accept;
  logic             emit;
  logic             shift_en;
  logic [CW-1:0]    rd_idx;
  logic [CLW-1:0]   new_col;
  logic [CLW-1:0]   cols [3];
  logic [DW-1:0]    tap;

  assign accept = bus.pixel_in_valid && ready_q;

  always_comb begin
    rd_idx = in_col_q;
    if (state_q == S_FLUSH) begin
      rd_idx = (flush_cnt_q == FLUSH_LAST) ? '0 : flush_cnt_q[CW-1:0];
    end
    // In flush the bottom row is the virtual zero row below the image.
    new_col = {(state_q == S_FLUSH) ? {DW{1'b0}} : bus.pixel_in,
               lb_mid_mem[rd_idx], lb_top_mem[rd_idx]};
  end

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    flush_cnt_d = flush_cnt_q;
    emit        = 1'b0;
    shift_en    = accept || (state_q == S_FLUSH);
    err_d       = err_q | (bus.pixel_in_valid & ~ready_q);

    case (state_q)
      S_FILL: begin
        if (accept) begin
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
          if (in_row_q == ROW_ONE && in_col_q == '0) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (in_row_q == ROW_LAST && in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = '0;
            state_d  = S_FLUSH;
          end else if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            in_row_d = in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        emit = 1'b1;
        if (flush_cnt_q == FLUSH_LAST) begin
          flush_cnt_d = '0;
          state_d     = S_FILL;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase

    ready_d = (state_d != S_FLUSH);
  end

  // Window assembly: centre column is col_a; when the centre sits on the last
  // column the freshly read column belongs to the next row and is replaced by padding.
  always_comb begin
    col_a_d     = col_a_q;
    col_b_d     = col_b_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    cols[0]     = col_b_q;
    cols[1]     = col_a_q;
    cols[2]     = (out_col_q == COL_LAST) ? '0 : new_col;
    tap         = '0;

    if (shift_en) begin
      col_a_d = new_col;
      col_b_d = col_a_q;
    end

    if (emit) begin
      win_valid_d = 1'b1;
      win_row_d   = out_row_q;
      win_col_d   = out_col_q;
      win_last_d  = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
      for (int dy = 0; dy < 3; dy++) begin
        for (int dx = 0; dx < 3; dx++) begin
          tap = cols[dx][dy*DW +: DW];
          if ((dy == 0 && out_row_q == '0) || (dy == 2 && out_row_q == ROW_LAST) ||
              (dx == 0 && out_col_q == '0) || (dx == 2 && out_col_q == COL_LAST)) begin
            tap = '0;
          end
          win_d[DW*(3*dy+dx) +: DW] = tap;
        end
      end
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      flush_cnt_q <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      flush_cnt_q <= flush_cnt_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_q       <= win_d;
    end
  end

  // Stale history and line-buffer contents are always masked, so no reset is needed.
  always_ff @(posedge clk) begin
    col_a_q <= col_a_d;
    col_b_q <= col_b_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_mem[in_col_q] <= lb_mid_mem[in_col_q];
      lb_mid_mem[in_col_q] <= bus.pixel_in;
    end
  end

  assign bus.pixel_in_ready = ready_q;
  assign bus.win_out        = win_q;
  assign bus.win_valid      = win_valid_q;
  assign bus.win_row        = win_row_q;
  assign bus.win_col        = win_col_q;
  assign bus.win_last       = win_last_q;
  assign bus.err_drop       = err_q;

endmodule

// File: tb/tb_hw_accel_window_3x3.sv
// Directed bench for the 3x3 window generator on a 4x3 image.
module tb_hw_accel_window_3x3;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   img [N];
  int   acc6;
  int   fl_cnt;
  int   base;

  logic [71:0] wq [$];
  int          rq [$];
  int          cq [$];
  int          lq [$];
  int          cycq [$];

  hw_accel_window_3x3_if #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  hw_accel_window_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.win_valid) begin
      wq.push_back(bus.win_out);
      rq.push_back(int'(bus.win_row));
      cq.push_back(int'(bus.win_col));
      lq.push_back(int'(bus.win_last));
      cycq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [71:0] pack9(input int t0, input int t1, input int t2,
                                        input int t3, input int t4, input int t5,
                                        input int t6, input int t7, input int t8);
    int t [9];
    logic [71:0] w;
    t = '{t0, t1, t2, t3, t4, t5, t6, t7, t8};
    w = '0;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = t[i][7:0];
    return w;
  endfunction

  function automatic logic [71:0] model_win(input int y, input int x);
    logic [71:0] w;
    int yy, xx, v;
    w = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        yy = y + dy - 1;
        xx = x + dx - 1;
        v = (yy >= 0 && yy < H && xx >= 0 && xx < W) ? img[yy*W + xx] : 0;
        w[8*(3*dy+dx) +: 8] = v[7:0];
      end
    end
    return w;
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.pixel_in = d;
    bus.pixel_in_valid = v;
  endtask

  task automatic flush_wait(input logic hold, output int cnt);
    @(negedge clk);
    bus.pixel_in = 8'hEE;
    bus.pixel_in_valid = hold;
    cnt = 0;
    while (bus.pixel_in_ready == 1'b0 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    bus.pixel_in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input logic hold);
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 3 == 1)) step(1'b0, 8'h00);
      step(1'b1, img[i][7:0]);
      if (i == 5) acc6 = cyc;
    end
    flush_wait(hold, fl_cnt);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
  endtask

  task automatic check_frame(input int b, input string nm);
    int n;
    chk($sformatf("%s_count", nm), 72'(wq.size() - b), 72'(N));
    for (n = 0; n < N; n++) begin
      if (b + n < wq.size()) begin
        chk($sformatf("%s_win%0d", nm, n), wq[b+n], model_win(n / W, n % W));
        chk($sformatf("%s_pos%0d", nm, n), 72'(rq[b+n] * W + cq[b+n]), 72'(n));
        chk($sformatf("%s_last%0d", nm, n), 72'(lq[b+n]), 72'(n == N - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at time limit, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pixel_in = '0;
    bus.pixel_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 72'(bus.pixel_in_ready), 72'(0));
    chk("rst_valid", 72'(bus.win_valid), 72'(0));
    chk("rst_win", bus.win_out, 72'(0));
    chk("rst_err", 72'(bus.err_drop), 72'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 72'(bus.pixel_in_ready), 72'(1));

    // Frame A: 1..12 back-to-back
    for (int i = 0; i < N; i++) img[i] = i + 1;
    base = wq.size();
    send_frame(1'b0, 1'b0);
    check_frame(base, "A");
    chk("A_flush_len", 72'(fl_cnt), 72'(5));
    chk("A_err", 72'(bus.err_drop), 72'(0));
    chk("A_ready_back", 72'(bus.pixel_in_ready), 72'(1));
    if (wq.size() >= base + N) begin
      chk("A_first_lat", 72'(cycq[base] - acc6), 72'(1));
      chk("A_w00", wq[base], pack9(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk("A_w11", wq[base+5], pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk("A_w13", wq[base+7], pack9(3, 4, 0, 7, 8, 0, 11, 12, 0));
      chk("A_w23", wq[base+11], pack9(7, 8, 0, 11, 12, 0, 0, 0, 0));
      chk("A_flush_b2b", 72'(cycq[base+11] - cycq[base+7]), 72'(4));
    end

    // Frame B: input gaps, valid held high through the flush
    for (int i = 0; i < N; i++) img[i] = 100 + 11 * i;
    base = wq.size();
    send_frame(1'b1, 1'b1);
    check_frame(base, "B");
    chk("B_flush_len", 72'(fl_cnt), 72'(5));
    chk("B_err", 72'(bus.err_drop), 72'(1));
    if (wq.size() > base) chk("B_w00", wq[base], pack9(0, 0, 0, 0, 100, 111, 0, 144, 155));

    // Frame C: dropped flush pixels must not shift this frame
    for (int i = 0; i < N; i++) img[i] = 250 - 17 * i;
    base = wq.size();
    send_frame(1'b0, 1'b0);
    check_frame(base, "C");

    // Partial frame into row 1, then asynchronous reset
    for (int i = 0; i < 6; i++) step(1'b1, 8'hAA);
    @(negedge clk);
    bus.pixel_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 72'(bus.win_valid), 72'(0));
    chk("mid_rst_win", bus.win_out, 72'(0));
    chk("mid_rst_ready", 72'(bus.pixel_in_ready), 72'(0));
    chk("mid_rst_err", 72'(bus.err_drop), 72'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame D after reset
    for (int i = 0; i < N; i++) img[i] = 12 - i;
    base = wq.size();
    send_frame(1'b0, 1'b0);
    check_frame(base, "D");
    chk("D_err", 72'(bus.err_drop), 72'(0));
    chk("D_flush_len", 72'(fl_cnt), 72'(5));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
